// File: rtl/ntt_pkg.sv
// ntt_pkg: constants shared by the q = 12289 NTT processing elements and controller
package ntt_pkg;
    localparam int Q          = 12289;
    localparam int BARRETT_K  = 28;
    localparam int BARRETT_M  = 21843;
    localparam int DATA_WIDTH = 14;
    localparam int PE_LAT     = 6;

    function automatic longint barrett_m(input int q);
        return (longint'(1) << BARRETT_K) / longint'(q);
    endfunction
endpackage

// File: rtl/barrett_reduce.sv
// barrett_reduce: four-stage Barrett reduction of a product p < Q^2 into [0, Q)
module barrett_reduce import ntt_pkg::*; #(
    parameter int data_width = DATA_WIDTH,
    parameter int Q          = ntt_pkg::Q
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*data_width-1:0] p,
    output logic [data_width-1:0]   r
);
    localparam longint M = barrett_m(Q);

    logic [2*data_width-1:0] p3;
    logic [16:0]             qhat3, qhat_c;
    logic [15:0]             r4, r5, r_c;

    assign qhat_c = 17'((45'(p) * 45'(M)) >> BARRETT_K);
    assign r_c    = 16'(32'(p3) - 32'(qhat3) * 32'(Q));

    // quotient estimate, raw remainder (< 3Q), then two conditional subtractions
    always_ff @(posedge clk) begin
        if (rst) begin
            p3    <= '0;
            qhat3 <= '0;
            r4    <= '0;
            r5    <= '0;
            r     <= '0;
        end else begin
            p3    <= p;
            qhat3 <= qhat_c;
            r4    <= r_c;
            r5    <= r4 >= 16'(Q) ? r4 - 16'(Q) : r4;
            r     <= data_width'(r5 >= 16'(Q) ? r5 - 16'(Q) : r5);
        end
    end
endmodule

// File: rtl/shift_3.sv
// shift_3: three-stage delay line with synchronous clear
module shift_3 #(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);
    logic [width-1:0] s1, s2;

    // shift one stage per cycle; reset empties the whole line
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
            q  <= s2;
        end
    end
endmodule

// File: rtl/pe_twiddle_mul.sv
// pe_twiddle_mul: six-cycle v*w mod Q twiddle stage with u/sel/valid carried alongside
module pe_twiddle_mul import ntt_pkg::*; #(
    parameter int data_width = DATA_WIDTH,
    parameter int Q          = ntt_pkg::Q
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  sel,
    input  logic [data_width-1:0] u,
    input  logic [data_width-1:0] v,
    input  logic [data_width-1:0] w,
    output logic                  out_valid,
    output logic                  sel_out,
    output logic [data_width-1:0] u_out,
    output logic [data_width-1:0] vw_out
);
    localparam int pw = 2 * data_width;

    logic [data_width-1:0] v1, w1;
    logic [pw-1:0]         p2;
    logic [data_width+1:0] mid, tail;

    // operand capture and full-width product; data registers load every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= '0;
            w1 <= '0;
            p2 <= '0;
        end else begin
            v1 <= v;
            w1 <= w;
            p2 <= pw'(v1) * pw'(w1);
        end
    end

    barrett_reduce #(.data_width(data_width), .Q(Q)) u_red (
        .clk (clk),
        .rst (rst),
        .p   (p2),
        .r   (vw_out)
    );

    shift_3 #(.width(data_width + 2)) u_dly0 (
        .clk (clk),
        .rst (rst),
        .d   ({in_valid, sel, u}),
        .q   (mid)
    );

    shift_3 #(.width(data_width + 2)) u_dly1 (
        .clk (clk),
        .rst (rst),
        .d   (mid),
        .q   (tail)
    );

    assign {out_valid, sel_out, u_out} = tail;
endmodule

// File: doc/pe_twiddle_mul.md
# pe_twiddle_mul

Pipelined twiddle-multiply stage that pairs with the add/sub/halve butterfly PE (`PE1`) in the radix-4, 4x2 BFU array for q = 12289.
- Forward NTT (`sel`=0, Cooley-Tukey): sits before the butterfly. It computes v·w mod q and forwards u unchanged.
- Inverse NTT (`sel`=1, Gentleman-Sande): sits after the butterfly. It multiplies the butterfly's upper output by the inverse twiddle.

Latency is fixed at 6 cycles so the stage lines up with the butterfly's 3+3 pipeline without extra skew registers.

## Interface
- `data_width`, default 14: coefficient width. Must be ≥ ceil(log2 q).
- `Q`, default 12289: modulus.
- `clk`  input  1: clock. All logic is rising-edge.
- `rst`  input  1: reset. Synchronous, active-high.
- `in_valid`  input  1: the inputs on this cycle are a valid operand set.
- `sel`  input  1: direction tag. 0 = forward, 1 = inverse. It is carried through the pipeline and does not change the arithmetic.
- `u`  input  `data_width`: pass-through operand.
- `v`  input  `data_width`: multiplicand.
- `w`  input  `data_width`: twiddle factor, either ω^k or ω^-k (chosen by the caller).
- `out_valid`  output  1: outputs are valid.
- `sel_out`  output  1: `sel` delayed by 6 cycles.
- `u_out`  output  `data_width`: `u` delayed by 6 cycles.
- `vw_out`  output  `data_width`: (v·w) mod Q, delayed by 6 cycles.

## Operation
- Input contract: u, v and w are all < Q. Behaviour for out-of-range inputs is not required and is not checked.
- Barrett reduction with k = 28 and M = floor(2^28 / Q) = 21843:
  - p = v·w is 28 bits; p ≤ (Q−1)² < 2^28.
  - qhat = (p·M) >> 28.
  - r = p − qhat·Q, held in 16 bits. r < 3Q is guaranteed.
  - Apply up to two conditional subtractions of Q, so the final result is in [0, Q).
- Pipeline stages, one register bank each:
  - S1: register u, v, w, sel, in_valid.
  - S2: p = v·w.
  - S3: t = p·M (45-bit product); keep bits [44:28] as qhat.
  - S4: r = p − qhat·Q; keep the low 16 bits only.
  - S5: r1 = (r ≥ Q) ? r − Q : r.
  - S6: vw = (r1 ≥ Q) ? r1 − Q : r1.
- `u`, `sel` and `valid` travel in a 6-deep shift register alongside the arithmetic.
- There is no backpressure and no stall. The stage accepts one operand set per cycle, every cycle.
- Data registers may capture on every cycle regardless of valid (power is not a concern here). Only the `valid` chain is qualified.
- Outputs are registered: the S6 registers drive the ports directly.

## Timing
- Latency is exactly 6 cycles: inputs sampled at edge n appear on the outputs after edge n+5 and are stable during cycle n+6. This matches the butterfly PE.
- Throughput is 1 operand set per cycle. Bubbles (`in_valid`=0) propagate as `out_valid`=0 in the same relative position.
- Reset:
  - While `rst` is high at a clock edge, every pipeline register clears to 0. All outputs, including `out_valid` and `sel_out`, read 0 from the following cycle.
  - Reset mid-stream discards all in-flight operands; none reappear afterwards.
  - Inputs presented in the same cycle `rst` is high are dropped.
  - After `rst` deasserts, the first accepted operand emerges 6 cycles later. No spurious `out_valid` pulse precedes it.
- Simultaneous `in_valid` and `rst`: reset wins.
- `sel` may toggle on any cycle. Each result carries the `sel` it entered with.

## Structure
- Shared package `ntt_pkg`, holding:
  - `Q`=12289, `BARRETT_K`=28, `BARRETT_M`=21843;
  - the coefficient width;
  - the pipeline depth constant `PE_LAT`=6, shared with the butterfly PE and the controller.
- One sub-module, `barrett_reduce`, containing the S3–S6 stages with a valid-less data path. It is reusable by other PEs.
- The pass-through delay line reuses the existing `shift_3` module, instantiated twice.

## Test plan
- Reset, then a single set v=2, w=3, u=5, sel=0 → exactly 6 cycles later `out_valid`=1, `vw_out`=6, `u_out`=5, `sel_out`=0.
- Boundary products, run back-to-back:
  - v=12288, w=12288 → 1;
  - v=12288, w=2 → 12287;
  - v=0, w=12288 → 0;
  - v=7000, w=9000 → 6586.
  - Expect results on consecutive cycles, in order.
- 1000 random in-range sets with random `in_valid` gaps and random `sel` → every output matches a reference model (v·w mod Q) with exact cycle alignment. `out_valid` follows the gap pattern, and `sel_out`/`u_out` match per operand.
- Assert `rst` for 1 cycle while 4 operands are in flight → outputs are 0 from the next cycle, none of the 4 ever appear, and a new operand issued right after reset appears 6 cycles later.
- Chain with the butterfly PE in forward mode. With u=100, v=200, w=3, the product stage gives 600 and the butterfly then gives lower = 700 and upper = (100−600) mod Q = 11789, i.e. (u − v·w) mod Q. Check the total latency of 12 cycles.
